// File: rtl/video_pattern_pkg.sv
// video_pattern_pkg: pattern codes, colour-bar table and pipeline latency shared
// by the video pattern generator blocks.
package video_pattern_pkg;

  localparam logic [2:0] PATTERN_BARS    = 3'd0;
  localparam logic [2:0] PATTERN_GRAY    = 3'd1;
  localparam logic [2:0] PATTERN_CHECKER = 3'd2;
  localparam logic [2:0] PATTERN_MOVING  = 3'd3;
  localparam logic [2:0] PATTERN_SOLID   = 3'd4;

  localparam int PATTERN_LATENCY = 2;

  // {r,g,b} full-scale flags; index 0 is the leftmost bar.
  localparam logic [2:0] BAR_RGB [8] = '{
    3'b111, 3'b110, 3'b011, 3'b010, 3'b101, 3'b100, 3'b001, 3'b000
  };

endpackage

// File: rtl/pattern_strobe_delay.sv
// pattern_strobe_delay: fixed-depth shift register that keeps raster strobes
// aligned with a pipelined pixel path.
module pattern_strobe_delay #(
  parameter int WIDTH  = 5,
  parameter int STAGES = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] i_strobes,
  output logic [WIDTH-1:0] o_strobes
);

  logic [WIDTH-1:0] r_pipe [STAGES];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < STAGES; i++) r_pipe[i] <= '0;
    end else begin
      r_pipe[0] <= i_strobes;
      for (int i = 1; i < STAGES; i++) r_pipe[i] <= r_pipe[i-1];
    end
  end

  assign o_strobes = r_pipe[STAGES-1];

endmodule

// File: rtl/video_pattern_generator.sv
// video_pattern_generator: five-pattern RGB test source, two clocks from raster
// strobes to pixels. Define PATTERN_AUTO_CYCLE_EN to step patterns every 64 frames.
module video_pattern_generator
  import video_pattern_pkg::*;
#(
  parameter int H_ACTIVE     = 1280,
  parameter int V_ACTIVE     = 720,
  parameter int H_POS_WIDTH  = 12,
  parameter int V_POS_WIDTH  = 11,
  parameter int COLOR_DEPTH  = 8,
  parameter int CHECKER_LOG2 = 5,
  parameter int MOVE_STEP    = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [2:0]               patternSelect,
  input  logic [3*COLOR_DEPTH-1:0] solidColor,
  input  logic                     dataEnable,
  input  logic                     hSync,
  input  logic                     vSync,
  input  logic [H_POS_WIDTH-1:0]   hPos,
  input  logic [V_POS_WIDTH-1:0]   vPos,
  input  logic                     activeVideoGuardBand,
  input  logic                     activeVideoPreamble,
  output logic [COLOR_DEPTH-1:0]   r,
  output logic [COLOR_DEPTH-1:0]   g,
  output logic [COLOR_DEPTH-1:0]   b,
  output logic                     dataEnableDelayed,
  output logic                     hSyncDelayed,
  output logic                     vSyncDelayed,
  output logic                     activeVideoGuardBandDelayed,
  output logic                     activeVideoPreambleDelayed,
  output logic [2:0]               activePattern
);

  // Streaming interface without backpressure: every clock carries one raster
  // sample in, and the matching pixel plus strobes leave PATTERN_LATENCY clocks later.
  localparam int BAR_WIDTH = H_ACTIVE / 8;
  localparam int BAR_CNT_W = $clog2(BAR_WIDTH + 1);
  localparam int ACC_W     = $clog2(H_ACTIVE + 2**COLOR_DEPTH) + 1;
  localparam int XW        = H_POS_WIDTH + 2;
  localparam int RGB_W     = 3 * COLOR_DEPTH;

  logic                   r_vsync_prev;
  logic                   w_frame_edge;
  logic [2:0]             r_pattern;
  logic [RGB_W-1:0]       r_solid;
  logic [XW-1:0]          r_bar_x;
  logic [XW-1:0]          w_bar_x_step;
  logic [XW-1:0]          w_bar_x_next;
  logic [BAR_CNT_W-1:0]   r_bar_pixel;
  logic [2:0]             r_bar_index;
  logic [ACC_W-1:0]       r_acc;
  logic [ACC_W-1:0]       w_acc_sum;
  logic [COLOR_DEPTH-1:0] r_level;
  logic [2:0]             w_bar_bits;
  logic                   w_checker;
  logic                   w_in_bar;
  logic [XW-1:0]          w_hpos_ext;
  logic [RGB_W-1:0]       w_rgb;
  logic [RGB_W-1:0]       r_rgb_s1;
  logic [RGB_W-1:0]       r_rgb_s2;
  logic [2:0]             r_pat_s1;
  logic [2:0]             r_pat_s2;
  logic [4:0]             w_strobes_d;
  logic                   w_unused_vpos;

  assign w_frame_edge  = vSync & ~r_vsync_prev;
  assign w_bar_x_step  = r_bar_x + XW'(MOVE_STEP);
  assign w_bar_x_next  = (w_bar_x_step >= XW'(H_ACTIVE)) ? w_bar_x_step - XW'(H_ACTIVE)
                                                         : w_bar_x_step;
  assign w_unused_vpos = ^vPos;

`ifdef PATTERN_AUTO_CYCLE_EN
  // Frame counter doubles as the auto-cycle divider; r_loaded marks reset release.
  logic       r_loaded;
  logic [7:0] r_frame_count;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_loaded      <= 1'b0;
      r_frame_count <= '0;
    end else begin
      r_loaded <= 1'b1;
      if (w_frame_edge) r_frame_count <= r_frame_count + 8'd1;
    end
  end
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_vsync_prev <= 1'b0;
      r_pattern    <= PATTERN_BARS;
      r_solid      <= '0;
      r_bar_x      <= '0;
    end else begin
      r_vsync_prev <= vSync;
      if (w_frame_edge) begin
        r_solid <= solidColor;
        r_bar_x <= w_bar_x_next;
      end
`ifdef PATTERN_AUTO_CYCLE_EN
      if (!r_loaded) begin
        r_pattern <= patternSelect;
      end else if (w_frame_edge && r_frame_count[5:0] == 6'd63) begin
        r_pattern <= (r_pattern >= PATTERN_SOLID) ? PATTERN_BARS : r_pattern + 3'd1;
      end
`else
      if (w_frame_edge) r_pattern <= patternSelect;
`endif
    end
  end

  // Bar and ramp counters hold the value for the pixel currently on the inputs.
  assign w_acc_sum = r_acc + ACC_W'(2**COLOR_DEPTH);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_bar_pixel <= '0;
      r_bar_index <= '0;
      r_acc       <= '0;
      r_level     <= '0;
    end else if (!dataEnable) begin
      r_bar_pixel <= '0;
      r_bar_index <= '0;
      r_acc       <= '0;
      r_level     <= '0;
    end else begin
      if (r_bar_pixel == BAR_CNT_W'(BAR_WIDTH - 1)) begin
        r_bar_pixel <= '0;
        if (r_bar_index != 3'd7) r_bar_index <= r_bar_index + 3'd1;
      end else begin
        r_bar_pixel <= r_bar_pixel + BAR_CNT_W'(1);
      end
      if (w_acc_sum >= ACC_W'(H_ACTIVE)) begin
        r_acc <= w_acc_sum - ACC_W'(H_ACTIVE);
        if (r_level != '1) r_level <= r_level + COLOR_DEPTH'(1);
      end else begin
        r_acc <= w_acc_sum;
      end
    end
  end

  assign w_bar_bits = BAR_RGB[r_bar_index];
  assign w_checker  = hPos[CHECKER_LOG2] ^ vPos[CHECKER_LOG2];
  assign w_hpos_ext = XW'(hPos);
  assign w_in_bar   = (w_hpos_ext >= r_bar_x) && (w_hpos_ext < r_bar_x + XW'(BAR_WIDTH));

  always_comb begin
    w_rgb = '0;
    case (r_pattern)
      PATTERN_BARS:    w_rgb = {{COLOR_DEPTH{w_bar_bits[2]}},
                                {COLOR_DEPTH{w_bar_bits[1]}},
                                {COLOR_DEPTH{w_bar_bits[0]}}};
      PATTERN_GRAY:    w_rgb = {3{r_level}};
      PATTERN_CHECKER: w_rgb = {RGB_W{w_checker}};
      PATTERN_MOVING:  w_rgb = {RGB_W{w_in_bar}};
      PATTERN_SOLID:   w_rgb = r_solid;
      default:         w_rgb = '0;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_rgb_s1 <= '0;
      r_rgb_s2 <= '0;
      r_pat_s1 <= '0;
      r_pat_s2 <= '0;
    end else begin
      r_rgb_s1 <= dataEnable ? w_rgb : '0;
      r_rgb_s2 <= r_rgb_s1;
      r_pat_s1 <= r_pattern;
      r_pat_s2 <= r_pat_s1;
    end
  end

  pattern_strobe_delay #(
    .WIDTH (5),
    .STAGES(PATTERN_LATENCY)
  ) u_strobe_delay (
    .clock    (clock),
    .reset    (reset),
    .i_strobes({dataEnable, hSync, vSync, activeVideoGuardBand, activeVideoPreamble}),
    .o_strobes(w_strobes_d)
  );

  assign {dataEnableDelayed, hSyncDelayed, vSyncDelayed,
          activeVideoGuardBandDelayed, activeVideoPreambleDelayed} = w_strobes_d;

  assign r             = r_rgb_s2[RGB_W-1 -: COLOR_DEPTH];
  assign g             = r_rgb_s2[2*COLOR_DEPTH-1 -: COLOR_DEPTH];
  assign b             = r_rgb_s2[COLOR_DEPTH-1:0];
  assign activePattern = r_pat_s2;

endmodule

// File: tb/tb_video_pattern_generator.sv
// tb_video_pattern_generator: randomized raster stimulus against a pixel-level
// reference model, with a stamped expected queue checked by a separate monitor.
module tb_video_pattern_generator;

  localparam logic [23:0] BAR_COL [8] = '{
    24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
    24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
  };

  // clock / reset
  logic        clock;
  logic        reset;
  logic [2:0]  patternSelect;
  logic [23:0] solidColor;
  logic        dataEnable, hSync, vSync;
  logic [11:0] hPos;
  logic [10:0] vPos;
  logic        activeVideoGuardBand, activeVideoPreamble;
  logic [7:0]  r, g, b;
  logic        dataEnableDelayed, hSyncDelayed, vSyncDelayed;
  logic        activeVideoGuardBandDelayed, activeVideoPreambleDelayed;
  logic [2:0]  activePattern;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  video_pattern_generator dut (
    .clock                      (clock),
    .reset                      (reset),
    .patternSelect              (patternSelect),
    .solidColor                 (solidColor),
    .dataEnable                 (dataEnable),
    .hSync                      (hSync),
    .vSync                      (vSync),
    .hPos                       (hPos),
    .vPos                       (vPos),
    .activeVideoGuardBand       (activeVideoGuardBand),
    .activeVideoPreamble        (activeVideoPreamble),
    .r                          (r),
    .g                          (g),
    .b                          (b),
    .dataEnableDelayed          (dataEnableDelayed),
    .hSyncDelayed               (hSyncDelayed),
    .vSyncDelayed               (vSyncDelayed),
    .activeVideoGuardBandDelayed(activeVideoGuardBandDelayed),
    .activeVideoPreambleDelayed (activeVideoPreambleDelayed),
    .activePattern              (activePattern)
  );

  // scoreboard state
  logic [31:0] exp_q[$];
  int          stamp_q[$];
  int          n_cmp = 0;
  int          n_err = 0;

  // reference model state
  logic [2:0]  m_pattern;
  logic [23:0] m_solid;
  int          m_barx;
  logic        m_vs_prev;
  int          m_frames;

  function automatic logic [31:0] dut_vec();
    return {r, g, b, dataEnableDelayed, hSyncDelayed, vSyncDelayed,
            activeVideoGuardBandDelayed, activeVideoPreambleDelayed, activePattern};
  endfunction

  task automatic model_reset();
    m_pattern = 3'd0;
    m_solid   = 24'h0;
    m_barx    = 0;
    m_vs_prev = 1'b0;
    m_frames  = 0;
    exp_q.delete();
    stamp_q.delete();
  endtask

  task automatic release_reset();
    @(posedge clock);
    #3 reset = 1'b1;
`ifdef PATTERN_AUTO_CYCLE_EN
    m_pattern = patternSelect;
`endif
  endtask

  task automatic check_zero(input string name);
    n_cmp++;
    if (dut_vec() !== 32'h0) begin
      n_err++;
      $display("FAIL %s got=%h required=00000000", name, dut_vec());
    end
  endtask

  // driver: one raster sample per clock, expected pixel pushed with its due cycle
  task automatic drive_px(input logic de, input logic hs, input logic vs,
                          input int x, input int y);
    logic [23:0] rgb;
    logic        gb, pre;
    int          lv;
    @(posedge clock);
    #1;
    gb  = 1'($urandom);
    pre = 1'($urandom);
    dataEnable           = de;
    hSync                = hs;
    vSync                = vs;
    hPos                 = 12'(x);
    vPos                 = 11'(y);
    activeVideoGuardBand = gb;
    activeVideoPreamble  = pre;
    rgb = 24'h0;
    if (de) begin
      case (m_pattern)
        3'd0: rgb = BAR_COL[x / 160];
        3'd1: begin
          lv = (x * 256) / 1280;
          if (lv > 255) lv = 255;
          rgb = {3{8'(lv)}};
        end
        3'd2: if (((x / 32) + (y / 32)) % 2 == 1) rgb = 24'hFFFFFF;
        3'd3: if (x >= m_barx && x < m_barx + 160) rgb = 24'hFFFFFF;
        3'd4: rgb = m_solid;
        default: rgb = 24'h0;
      endcase
    end
    exp_q.push_back({rgb, de, hs, vs, gb, pre, m_pattern});
    stamp_q.push_back(cyc + 2);
    if (vs && !m_vs_prev) begin
      m_solid = solidColor;
      m_barx  = (m_barx + 4) % 1280;
`ifdef PATTERN_AUTO_CYCLE_EN
      if (m_frames % 64 == 63) m_pattern = (m_pattern >= 3'd4) ? 3'd0 : m_pattern + 3'd1;
`else
      m_pattern = patternSelect;
`endif
      m_frames = (m_frames + 1) % 256;
    end
    m_vs_prev = vs;
  endtask

  task automatic blank(input int n);
    for (int i = 0; i < n; i++)
      drive_px(1'b0, 1'($urandom), 1'b0, $urandom_range(0, 4095), $urandom_range(0, 2047));
  endtask

  task automatic vsync_pulse();
    drive_px(1'b0, 1'b0, 1'b1, $urandom_range(0, 4095), $urandom_range(0, 2047));
    drive_px(1'b0, 1'b0, 1'b1, $urandom_range(0, 4095), $urandom_range(0, 2047));
    blank(2);
  endtask

  task automatic line(input int y);
    drive_px(1'b0, 1'b1, 1'b0, $urandom_range(0, 4095), y);
    drive_px(1'b0, 1'b1, 1'b0, $urandom_range(0, 4095), y);
    blank(2);
    for (int x = 0; x < 1280; x++) drive_px(1'b1, 1'b0, 1'b0, x, y);
    blank(2);
  endtask

  // monitor: compares each DUT pixel against the entry due on this cycle
  logic [31:0] mon_exp;
  int          mon_stamp;
  always @(negedge clock) begin
    if (reset && stamp_q.size() > 0 && stamp_q[0] <= cyc) begin
      mon_exp   = exp_q.pop_front();
      mon_stamp = stamp_q.pop_front();
      n_cmp++;
      if (mon_stamp != cyc || dut_vec() !== mon_exp) begin
        n_err++;
        $display("FAIL pixel_out due=%0d cyc=%0d got=%h required=%h",
                 mon_stamp, cyc, dut_vec(), mon_exp);
      end
    end
  end

  initial begin
    reset = 1'b0;
    patternSelect = 3'd3;
    solidColor = 24'h0;
    dataEnable = 1'b0; hSync = 1'b0; vSync = 1'b0;
    hPos = '0; vPos = '0;
    activeVideoGuardBand = 1'b0; activeVideoPreamble = 1'b0;
    model_reset();
    repeat (3) @(posedge clock);
    #2 check_zero("reset_state");
    release_reset();

    // first frame renders bars regardless of select, until the first vSync edge
    blank(3);
    line(5);

    // every code once, then random; selects changed mid-frame must not take effect
    for (int f = 0; f < 12; f++) begin
      patternSelect = (f < 8) ? 3'(f) : 3'($urandom_range(0, 7));
      solidColor = 24'($urandom);
      vsync_pulse();
      line($urandom_range(0, 719));
      if (f % 3 == 0) begin
        patternSelect = 3'($urandom_range(0, 7));
        solidColor = 24'($urandom);
        line($urandom_range(0, 719));
      end
    end

    // moving bar over many frames, sampling lines around the wrap
    patternSelect = 3'd3;
    for (int f = 0; f < 330; f++) begin
      vsync_pulse();
      if (m_barx >= 1260 || m_barx <= 4 || f % 41 == 0) line($urandom_range(0, 719));
    end

    // asynchronous reset in the middle of an active line
    patternSelect = 3'd1;
    vsync_pulse();
    blank(2);
    for (int x = 0; x < 600; x++) drive_px(1'b1, 1'b0, 1'b0, x, 7);
    #2 reset = 1'b0;
    #1 check_zero("reset_async");
    model_reset();
    repeat (2) @(posedge clock);
    patternSelect = 3'd4;
    solidColor = 24'($urandom);
    release_reset();
    blank(3);
    line(9);
    vsync_pulse();
    line(10);
    patternSelect = 3'd6;
    vsync_pulse();
    line(11);

    // every expected pixel must have been presented
    repeat (3) @(posedge clock);
    @(negedge clock);
    #1;
    n_cmp++;
    if (stamp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain left=%0d required=0", stamp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
